ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 8'hED set-LEDs, 8'hFF reset, 8'hF4 enable.
- Sits beside the existing PS/2 keyboard receiver on the same ps2_clk/ps2_dat pins.
- Drives both lines open-drain through active-high low-enables.
- Performs the inhibit / request-to-send sequence, shifts the frame on device-generated clocks, and reports the device's ACK bit or a timeout.

Parameters:
- INHIBIT_CYC, 5000: clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYC, 750000: max clk cycles from releasing ps2_clk to the ACK edge (15 ms at 50 MHz).
- FILT_LEN, 8: length of the ps2_clk glitch-filter shift register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  sampled PS/2 clock pin
- ps2_dat_in  in  1  sampled PS/2 data pin
- tx_data  in  8  byte to send; captured on accepted tx_start
- tx_start  in  1  one-cycle request; ignored while tx_busy=1
- tx_busy  out  1  high from accepted tx_start until the cycle after tx_done
- tx_done  out  1  one-cycle pulse at end of transfer
- tx_err  out  1  valid while tx_done=1; 1 = NACK or timeout, 0 = ACK received
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release
- ps2_dat_oe  out  1  1 = pull ps2_dat low, 0 = release

Behaviour:
- Reset: all outputs 0 immediately (asynchronous), so both lines are released. State is IDLE; counters and shift register are cleared.
- Reset asserted mid-transfer: lines release the same cycle; no tx_done is produced.
- Clock filter (sub-module):
  - ps2_clk_in passes a 2-FF synchronizer, then a FILT_LEN shift register.
  - Filtered level goes 1 when all taps are 1, goes 0 when all taps are 0, otherwise holds.
  - fall = one-cycle pulse on a filtered 1->0 transition.
  - Latency from pin edge to fall pulse is 2+FILT_LEN cycles. The filter resets to level 1.
- Frame: shift register frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data[7:0]}, loaded on accepted tx_start. Bits leave LSB first.
- On each sent bit, ps2_dat_oe = ~current bit: a 0 is driven low, a 1 is released.
- FSM states:
  - IDLE: clk_oe=0, dat_oe=0, busy=0. On tx_start, load frame, clear cycle counter, go INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0. After INHIBIT_CYC cycles go RTS.
  - RTS: clk_oe=1, dat_oe=1 (start bit) for exactly 1 cycle, then go SEND with clk_oe=0. Clear bitcnt and the watchdog.
  - SEND: clk_oe=0.
    - On each fall while bitcnt < 10, present frame[bitcnt] on dat_oe and increment bitcnt.
    - Falls 1..8 carry data bits, fall 9 carries parity, fall 10 carries stop (dat_oe=0).
    - At bitcnt==10, go ACK.
  - ACK: dat_oe=0. On the next fall (the 11th), sample the synchronized ps2_dat: 0 = ACK, 1 = NACK. Go DONE.
  - DONE: tx_done=1 for 1 cycle, tx_err = NACK | timeout, then IDLE.
- Watchdog:
  - Counts every cycle in SEND and ACK.
  - Reaching TIMEOUT_CYC forces DONE with tx_err=1 and releases both lines that cycle.
  - A fall arriving in the same cycle as the timeout loses to the timeout.
- tx_start while busy: ignored, with no queuing.
- tx_start in the same cycle as DONE: ignored; it is accepted only in IDLE.
- Falls seen in IDLE, INHIBIT or RTS are ignored.
- A fall arriving in the same cycle as RTS->SEND is not counted.
- tx_busy=1 signals the system to discard the receiver's ps2_done. The device's echo or ACK byte (8'hFA) arrives afterward as a normal received code.

Decomposition:
- Shared package ps2_pkg:
  - Command constants: PS2_CMD_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE.
  - FSM state encoding.
  - Default timing constants for 50 MHz.
- Sub-module ps2_line_filter (sync + filter + fall pulse), reusable by the receiver.

Test Plan:
(Bench overrides INHIBIT_CYC=20, TIMEOUT_CYC=2000; the device model clocks at 40 cycles per half-period.)
- 8'hED with model ACK=0 -> clk low 20 cycles; start 0; bits 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done with tx_err=0.
- 8'h01 -> parity bit 0. 8'h00 -> parity 1. 8'hFF -> parity 1. Model checks all frames and reports no error.
- Model holds ACK at 1 (NACK) -> tx_done=1, tx_err=1; both oe=0 afterward.
- Model never clocks -> tx_done after 2000 cycles in SEND, tx_err=1, ps2_dat_oe released at timeout.
- 2-cycle low glitches on ps2_clk_in during SEND -> bitcnt unchanged; frame intact.
- rst pulled low mid-SEND, then tx_start applied in a second transfer -> oe=0 immediately; no tx_done; tx_start again after release gives a clean frame and tx_err=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: command bytes, host-transmit FSM
// encoding and default timing for a 50 MHz system clock.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_LED    = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

    localparam int PS2_INHIBIT_CYC = 5000;
    localparam int PS2_TIMEOUT_CYC = 750000;
    localparam int PS2_FILT_LEN    = 8;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_INHIBIT = 3'd1,
        TX_RTS     = 3'd2,
        TX_SEND    = 3'd3,
        TX_ACK     = 3'd4,
        TX_DONE    = 3'd5
    } tx_state_e;

    // {stop, odd parity, data}; shifted out LSB first
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock-line conditioner: 2-FF synchronizer, all-taps
// glitch filter and a one-cycle falling-edge pulse.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = PS2_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic fall_o
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] taps_q;
    logic                level_q;
    logic                level_d;
    logic                all_hi;
    logic                all_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '1;
            taps_q  <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            taps_q  <= {taps_q[FILT_LEN-2:0], sync_q[1]};
            level_q <= level_d;
        end
    end

    assign all_hi = &taps_q;
    assign all_lo = ~|taps_q;

    always_comb begin
        level_d = level_q;
        if (all_hi)
            level_d = 1'b1;
        else if (all_lo)
            level_d = 1'b0;
    end

    // Combinational so the pulse lands 2+FILT_LEN cycles after the pin
    assign fall_o = level_q & all_lo;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// device-clocked frame shift and ACK/timeout reporting.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC,
    parameter int FILT_LEN    = PS2_FILT_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

    tx_state_e     state_q, state_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          bit_oe_q, bit_oe_d;
    logic          err_q, err_d;
    logic [1:0]    dat_sync_q;
    logic          clk_fall;
    logic          timeout;

    ps2_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_in),
        .fall_o (clk_fall)
    );

    assign timeout = (state_q == TX_SEND || state_q == TX_ACK)
                     && (wdog_q == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= TX_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:    if (tx_start) state_d = TX_INHIBIT;
            TX_INHIBIT: if (inh_q == INH_LAST) state_d = TX_RTS;
            TX_RTS:     state_d = TX_SEND;
            TX_SEND: begin
                if (timeout)
                    state_d = TX_DONE;
                else if (bitcnt_q == 4'd10)
                    state_d = TX_ACK;
            end
            TX_ACK:     if (timeout || clk_fall) state_d = TX_DONE;
            TX_DONE:    state_d = TX_IDLE;
            default:    state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy    = 1'b1;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        unique case (state_q)
            TX_IDLE:    tx_busy = 1'b0;
            TX_INHIBIT: ps2_clk_oe = 1'b1;
            TX_RTS: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
            end
            TX_SEND:    ps2_dat_oe = bit_oe_q & ~timeout;
            TX_ACK:     ps2_dat_oe = 1'b0;
            TX_DONE: begin
                tx_done = 1'b1;
                tx_err  = err_q;
            end
            default:    tx_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q    <= '0;
            bitcnt_q   <= '0;
            inh_q      <= '0;
            wdog_q     <= '0;
            bit_oe_q   <= 1'b0;
            err_q      <= 1'b0;
            dat_sync_q <= '1;
        end else begin
            frame_q    <= frame_d;
            bitcnt_q   <= bitcnt_d;
            inh_q      <= inh_d;
            wdog_q     <= wdog_d;
            bit_oe_q   <= bit_oe_d;
            err_q      <= err_d;
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    always_comb begin
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        inh_d    = inh_q;
        wdog_d   = wdog_q;
        bit_oe_d = bit_oe_q;
        err_d    = err_q;
        unique case (state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    frame_d = ps2_frame(tx_data);
                    inh_d   = '0;
                    err_d   = 1'b0;
                end
            end
            TX_INHIBIT: inh_d = inh_q + 1'b1;
            TX_RTS: begin
                bitcnt_d = '0;
                wdog_d   = '0;
                bit_oe_d = 1'b1;
            end
            TX_SEND: begin
                wdog_d = wdog_q + 1'b1;
                if (timeout) begin
                    err_d = 1'b1;
                end else if (clk_fall && bitcnt_q < 4'd10) begin
                    bit_oe_d = ~frame_q[0];
                    frame_d  = {1'b1, frame_q[9:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            TX_ACK: begin
                wdog_d = wdog_q + 1'b1;
                if (timeout)
                    err_d = 1'b1;
                else if (clk_fall)
                    err_d = dat_sync_q[1];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device
// model clocking at 40 system cycles per half-period.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dev_clk;
    logic       dev_dat;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic done_err = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs [4] = '{
        '{8'hED, 1'b1},
        '{8'h01, 1'b0},
        '{8'h00, 1'b1},
        '{8'hFF, 1'b1}
    };

    ps2_host_tx #(
        .INHIBIT_CYC (20),
        .TIMEOUT_CYC (2000),
        .FILT_LEN    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Open-drain wired-AND of host and device
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_err = tx_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        while (ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_entry", ps2_clk_oe, 1'b0);
    endtask

    task automatic dev_clock(input bit glitch, output logic b);
        for (int k = 0; k < HALF; k++) begin
            @(negedge clk);
            if (glitch)
                dev_clk = !(k == 15 || k == 16);
        end
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        b = ps2_dat_in;
        dev_clk = 1'b1;
    endtask

    task automatic wait_done(input int d0, input logic exp_err);
        int n = 0;
        #1;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_count", done_cnt - d0, 1);
        chk("done_err", done_err, exp_err);
        repeat (2) @(negedge clk);
        chk("idle_lines", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
    endtask

    task automatic dev_xfer(input logic [7:0] d, input logic par,
                            input logic ack, input bit glitch,
                            input bit poke, input logic exp_err);
        int         n;
        int         d0;
        logic [9:0] bits;
        logic       b;
        d0 = done_cnt;
        start_tx(d);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
            if (poke) begin
                tx_start = (n == 5);
                tx_data  = 8'hAA;
            end
            n++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        chk("inhibit_len", n, 20);
        chk("rts_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
        @(negedge clk);
        chk("start_bit", {ps2_clk_oe, ps2_dat_in}, 2'b00);
        for (int i = 0; i < 10; i++) begin
            dev_clock(glitch, b);
            bits[i] = b;
        end
        chk("data", bits[7:0], d);
        chk("parity", bits[8], par);
        chk("stop", bits[9], 1'b1);
        dev_dat = ack;
        dev_clock(1'b0, b);
        dev_dat = 1'b1;
        wait_done(d0, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   d0;
        logic pre;
        logic at;
        logic b;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #1;
        chk("reset_outputs",
            {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 5'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i])
            dev_xfer(vecs[i].data, vecs[i].par, 1'b0, 1'b0,
                     (i == 1), 1'b0);

        dev_xfer(PS2_CMD_LED, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        dev_xfer(PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Silent device: watchdog ends the transfer
        d0 = done_cnt;
        start_tx(PS2_CMD_RESET);
        wait_send();
        n   = 0;
        pre = 1'bx;
        at  = 1'bx;
        while (!tx_done && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1998) pre = ps2_dat_oe;
            if (n == 1999) at = ps2_dat_oe;
        end
        chk("to_len", n, 2000);
        chk("to_pre", pre, 1'b1);
        chk("to_rel", at, 1'b0);
        chk("to_err", tx_err, 1'b1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("to_done_count", done_cnt - d0, 1);
        chk("done_start_ignored", {ps2_clk_oe, tx_busy}, 2'b00);

        // Reset in the middle of SEND
        d0 = done_cnt;
        start_tx(PS2_CMD_LED);
        wait_send();
        dev_clock(1'b0, b);
        dev_clock(1'b0, b);
        chk("pre_rst_dat_oe", ps2_dat_oe, 1'b1);
        repeat (20) @(negedge clk);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_lines", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done}, 4'b0);
        dev_clk  = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        repeat (5) @(negedge clk);
        tx_start = 1'b0;
        rst      = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
        dev_xfer(PS2_CMD_LED, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
